tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised successor to the single-tone light-and-sound lab block.
- Plays a programmable note sequence on N independent square-wave channels.
- All channels share one step timer, derived from the board clock frequency.
- Sits between the key/switch front-end and the buzzer/LED pins. Also drives per-channel activity LEDs and a mixed sound output.

Parameters:
- clk_mhz, 50, board clock frequency in MHz.
- step_ms, 250, duration of one sequence step in ms. step_cycles = clk_mhz*1000*step_ms.
- n_channels, 2, number of tone channels (>=1).
- seq_depth, 8, entries per channel sequence memory (power of 2, >=2).
- divider_width, 24, width of a half-period value in clock cycles.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write one sequence entry this cycle.
- wr_ch  in  max(1,$clog2(n_channels))  channel to write.
- wr_addr  in  $clog2(seq_depth)  entry index.
- wr_data  in  divider_width  half-period in cycles; 0 = rest.
- seq_len  in  $clog2(seq_depth+1)  number of steps to play; sampled on start.
- loop  in  1  1 = wrap to step 0 after the last step; sampled on start.
- start  in  1  begin playback (level; acted on only in IDLE).
- stop  in  1  abort playback.
- tone  out  n_channels  per-channel square wave.
- sound  out  1  XOR of all tone bits.
- active  out  n_channels  1 while the channel's current entry is nonzero.
- step_idx  out  $clog2(seq_depth)  current step.
- busy  out  1  1 in PLAY.
- done  out  1  one-cycle pulse on non-loop completion.

Behaviour:
- Async reset (reset_n=0):
  - state IDLE.
  - Every output is 0.
  - All memory entries are 0, timers are 0, latched length/loop are 0.
- Memory writes:
  - Writes are accepted in any state.
  - wr_ch >= n_channels is ignored.
  - Each channel's half-period register loads from memory only at a step boundary. A write to the currently playing entry is heard the next time that step is loaded.
- States: IDLE and PLAY.
- IDLE -> PLAY: start=1, stop=0, seq_len!=0. On the next edge:
  - busy=1, step_idx=0.
  - seq_len and loop are latched.
  - Each channel loads entry 0.
  - Step timer is set to 0.
  - start with seq_len=0 is ignored.
- PLAY:
  - The step timer counts 0..step_cycles-1.
  - At terminal count, if step_idx < len-1: step_idx+1 and the next entries are loaded.
  - If step_idx == len-1 and loop=1: step_idx=0 and entry 0 is reloaded. No done pulse.
  - If step_idx == len-1 and loop=0: go to IDLE; done=1 for exactly one cycle; tone, active and step_idx go to 0.
- PLAY + stop=1: IDLE on the next edge. tone, active and step_idx go to 0 and no done pulse is issued.
  - stop has priority over start and over a simultaneous step boundary.
  - start while in PLAY is ignored.
- Tone generator per channel, with half-period H:
  - H=0: tone=0 and active=0.
  - H!=0: counter 0..H-1; tone toggles when the counter reaches H-1, giving period 2H cycles.
  - At each step load the counter and tone are cleared to 0. The first toggle comes H cycles after the load.
- Latency:
  - Registered outputs.
  - First tone toggle is H cycles after the busy rising edge.
  - Step length is exactly step_cycles.
  - done asserts on the same edge that busy falls.
- Width rules:
  - Step timer width is $clog2(step_cycles).
  - Divider counter width is divider_width; H up to 2^divider_width-1 is legal.

Decomposition:
- Package tone_seq_pkg holds:
  - the state encoding (IDLE=0, PLAY=1);
  - a clog2-based width helper;
  - the step_cycles localparam formula.
- Sub-module tone_divider:
  - One instance per channel, generated.
  - Inputs: clk, reset_n, load, half_period.
  - Outputs: tone, active.
- The top level holds the sequence memory, step timer and FSM.

Test Plan (clk_mhz=1, step_ms=1 -> step_cycles=1000; n_channels=2, seq_depth=4, divider_width=8):
- Reset: hold reset_n=0 mid-cycle -> tone, sound, active, busy, done and step_idx all 0 immediately, asynchronously. The same holds when asserted during PLAY.
- One-shot playback:
  - Setup: program ch0={2,3,0,5}, ch1={4,4,4,4}; seq_len=3, loop=0; pulse start.
  - Step 0: busy=1; tone[0] period 4, tone[1] period 8.
  - Step 1: tone[0] period 6.
  - Step 2: tone[0]=0 and active[0]=0; sound follows tone[1].
  - After 3000 cycles: done pulses one cycle and busy=0.
- Loop: same program with loop=1 -> at cycle 3000 step_idx wraps 2->0, tone[0] resumes period 4, done never asserts; stop -> busy=0 on the next edge.
- Priority:
  - start+stop in the same cycle in IDLE -> stays IDLE.
  - stop coinciding with the last-step terminal count in non-loop mode -> IDLE with done=0.
  - start with seq_len=0 -> busy stays 0.
- Live write: during step 0 write ch0 addr0=7 -> the step-0 period stays 4 until loop wraparound, then becomes 14; a write with wr_ch=2 is ignored.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared types and width helpers for the tone sequencer.
package tone_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Like $clog2 but never returns 0, so a 1-entry range still gets a 1-bit field.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

    function automatic int step_cycles_of(input int clk_mhz, input int step_ms);
        return clk_mhz * 1000 * step_ms;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// One square-wave channel: toggles every half_period cycles, silent when the period is 0.
module tone_divider #(
    parameter int width = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [width-1:0] half_period,
    output logic             tone,
    output logic             active
);

    logic [width-1:0] half_q;
    logic [width-1:0] count;

    // A load restarts the waveform from a low phase so the first edge lands H cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_q <= '0;
            count  <= '0;
            tone   <= 1'b0;
            active <= 1'b0;
        end else if (load) begin
            half_q <= half_period;
            count  <= '0;
            tone   <= 1'b0;
            active <= (half_period != '0);
        end else if (half_q != '0) begin
            if (count == half_q - 1'b1) begin
                count <= '0;
                tone  <= ~tone;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-channel note sequencer: per-channel sequence memory, shared step timer and play FSM.
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int clk_mhz       = 50,
    parameter int step_ms       = 250,
    parameter int n_channels    = 2,
    parameter int seq_depth     = 8,
    parameter int divider_width = 24
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 wr_en,
    input  logic [clog2_min1(n_channels)-1:0]    wr_ch,
    input  logic [$clog2(seq_depth)-1:0]         wr_addr,
    input  logic [divider_width-1:0]             wr_data,
    input  logic [$clog2(seq_depth+1)-1:0]       seq_len,
    input  logic                                 loop,
    input  logic                                 start,
    input  logic                                 stop,
    output logic [n_channels-1:0]                tone,
    output logic                                 sound,
    output logic [n_channels-1:0]                active,
    output logic [$clog2(seq_depth)-1:0]         step_idx,
    output logic                                 busy,
    output logic                                 done
);

    localparam int STEP_CYCLES = step_cycles_of(clk_mhz, step_ms);
    localparam int TW          = clog2_min1(STEP_CYCLES);
    localparam int AW          = $clog2(seq_depth);
    localparam int LW          = $clog2(seq_depth + 1);

    logic [divider_width-1:0] mem [n_channels][seq_depth];

    state_t          state;
    logic [TW-1:0]   timer;
    logic [LW-1:0]   len_q;
    logic            loop_q;

    logic            load;
    logic            load_zero;
    logic [AW-1:0]   load_idx;
    logic            terminal;
    logic            last_step;
    logic            go;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < n_channels; c++) begin
                for (int a = 0; a < seq_depth; a++) begin
                    mem[c][a] <= '0;
                end
            end
        end else if (wr_en && int'(wr_ch) < n_channels) begin
            mem[wr_ch][wr_addr] <= wr_data;
        end
    end

    // Load strobe for the dividers; a zero load is how stop/completion silences every channel.
    always_comb begin
        load      = 1'b0;
        load_zero = 1'b0;
        load_idx  = '0;
        go        = start && !stop && (seq_len != '0);
        terminal  = (timer == TW'(STEP_CYCLES - 1));
        last_step = (int'(step_idx) + 1 >= int'(len_q));
        case (state)
            IDLE: begin
                if (go) begin
                    load = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    load      = 1'b1;
                    load_zero = 1'b1;
                end else if (terminal) begin
                    load = 1'b1;
                    if (!last_step) begin
                        load_idx = step_idx + 1'b1;
                    end else if (!loop_q) begin
                        load_zero = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // stop outranks both a pending start and a step boundary on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            timer    <= '0;
            len_q    <= '0;
            loop_q   <= 1'b0;
            step_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= PLAY;
                        busy     <= 1'b1;
                        step_idx <= '0;
                        timer    <= '0;
                        len_q    <= seq_len;
                        loop_q   <= loop;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        step_idx <= '0;
                        timer    <= '0;
                    end else if (terminal) begin
                        timer <= '0;
                        if (!last_step) begin
                            step_idx <= step_idx + 1'b1;
                        end else if (loop_q) begin
                            step_idx <= '0;
                        end else begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            step_idx <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < n_channels; c++) begin : g_ch
        tone_divider #(
            .width(divider_width)
        ) u_div (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (load),
            .half_period(load_zero ? '0 : mem[c][load_idx]),
            .tone       (tone[c]),
            .active     (active[c])
        );
    end

    assign sound = ^tone;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer against an elapsed-time reference model.
module tb_tone_sequencer;

    localparam int STEP  = 1000;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       wr_en    = 1'b0;
    logic [0:0] wr_ch    = '0;
    logic [1:0] wr_addr  = '0;
    logic [7:0] wr_data  = '0;
    logic [2:0] seq_len  = '0;
    logic       loop     = 1'b0;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic [1:0] tone;
    logic       sound;
    logic [1:0] active;
    logic [1:0] step_idx;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_done_seen = 0;

    int m_mem [NCH][DEPTH];
    bit m_busy;
    bit m_loop;
    bit m_done;
    int m_len;
    int m_elapsed;
    int m_ldh [NCH];
    int m_ldcyc [NCH];

    tone_sequencer #(
        .clk_mhz      (1),
        .step_ms      (1),
        .n_channels   (NCH),
        .seq_depth    (DEPTH),
        .divider_width(8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .seq_len (seq_len),
        .loop    (loop),
        .start   (start),
        .stop    (stop),
        .tone    (tone),
        .sound   (sound),
        .active  (active),
        .step_idx(step_idx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int a = 0; a < DEPTH; a++) m_mem[c][a] = 0;
            m_ldh[c]   = 0;
            m_ldcyc[c] = 0;
        end
        m_busy = 0; m_loop = 0; m_done = 0; m_len = 0; m_elapsed = 0;
    endfunction

    function automatic void model_load(int idx, bit zero);
        for (int c = 0; c < NCH; c++) begin
            m_ldh[c]   = zero ? 0 : m_mem[c][idx];
            m_ldcyc[c] = cyc;
        end
    endfunction

    // Playback position is total elapsed cycles; a step is STEP cycles, a pass is len*STEP.
    function automatic void model_edge();
        m_done = 0;
        if (!m_busy) begin
            if (start && !stop && seq_len != 3'd0) begin
                m_busy = 1; m_elapsed = 0; m_len = int'(seq_len); m_loop = loop;
                model_load(0, 0);
            end
        end else if (stop) begin
            m_busy = 0; m_elapsed = 0;
            model_load(0, 1);
        end else begin
            m_elapsed++;
            if (m_elapsed == m_len * STEP) begin
                m_elapsed = 0;
                if (m_loop) model_load(0, 0);
                else begin
                    m_busy = 0; m_done = 1;
                    model_load(0, 1);
                end
            end else if (m_elapsed % STEP == 0) begin
                model_load(m_elapsed / STEP, 0);
            end
        end
        if (wr_en && int'(wr_ch) < NCH) m_mem[wr_ch][wr_addr] = int'(wr_data);
    endfunction

    task automatic check_output(string tag);
        logic [1:0] e_tone;
        logic [1:0] e_act;
        logic [1:0] e_idx;
        for (int c = 0; c < NCH; c++) begin
            if (m_ldh[c] == 0) begin
                e_tone[c] = 1'b0;
                e_act[c]  = 1'b0;
            end else begin
                e_tone[c] = 1'(((cyc - m_ldcyc[c]) / m_ldh[c]) % 2);
                e_act[c]  = 1'b1;
            end
        end
        e_idx = m_busy ? 2'(m_elapsed / STEP) : 2'd0;
        n_tests++;
        assert (tone === e_tone) else begin
            n_fail++; $error("FAIL %s tone: got %b expected %b at cycle %0d", tag, tone, e_tone, cyc);
        end
        n_tests++;
        assert (sound === ^e_tone) else begin
            n_fail++; $error("FAIL %s sound: got %b expected %b at cycle %0d", tag, sound, ^e_tone, cyc);
        end
        n_tests++;
        assert (active === e_act) else begin
            n_fail++; $error("FAIL %s active: got %b expected %b at cycle %0d", tag, active, e_act, cyc);
        end
        n_tests++;
        assert (step_idx === e_idx) else begin
            n_fail++; $error("FAIL %s step_idx: got %0d expected %0d at cycle %0d", tag, step_idx, e_idx, cyc);
        end
        n_tests++;
        assert (busy === m_busy) else begin
            n_fail++; $error("FAIL %s busy: got %b expected %b at cycle %0d", tag, busy, m_busy, cyc);
        end
        n_tests++;
        assert (done === m_done) else begin
            n_fail++; $error("FAIL %s done: got %b expected %b at cycle %0d", tag, done, m_done, cyc);
        end
    endtask

    task automatic step_cycle(string tag);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (done === 1'b1) n_done_seen++;
        check_output(tag);
    endtask

    task automatic run(int n, string tag);
        repeat (n) step_cycle(tag);
    endtask

    task automatic write_entry(int ch, int addr, int data);
        wr_en = 1'b1; wr_ch = 1'(ch); wr_addr = 2'(addr); wr_data = 8'(data);
        step_cycle("write");
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(int len, bit lp);
        seq_len = 3'(len); loop = lp; start = 1'b1;
        step_cycle("start");
        start = 1'b0;
    endtask

    task automatic check_count(string tag, int got, int want);
        n_tests++;
        assert (got == want) else begin
            n_fail++; $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic program_plan();
        write_entry(0, 0, 2); write_entry(0, 1, 3); write_entry(0, 2, 0); write_entry(0, 3, 5);
        for (int a = 0; a < DEPTH; a++) write_entry(1, a, 4);
    endtask

    function automatic int rand_h();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 9) return 255;
        return $urandom_range(1, 12);
    endfunction

    initial begin
        model_reset();
        #3;
        check_output("reset_hold");
        #14;
        reset_n = 1'b1;

        program_plan();
        n_done_seen = 0;
        pulse_start(3, 1'b0);
        run(3005, "one_shot");
        check_count("one_shot_done_pulses", n_done_seen, 1);

        n_done_seen = 0;
        pulse_start(3, 1'b1);
        run(100, "loop");
        write_entry(0, 0, 7);
        run(3300, "loop_live_write");
        stop = 1'b1;
        step_cycle("loop_stop");
        stop = 1'b0;
        run(10, "after_stop");
        check_count("loop_done_pulses", n_done_seen, 0);
        check_count("busy_after_stop", int'(busy), 0);

        seq_len = 3'd3; start = 1'b1; stop = 1'b1;
        step_cycle("start_stop_idle");
        start = 1'b0; stop = 1'b0;
        run(5, "start_stop_idle");
        check_count("busy_after_start_stop", int'(busy), 0);

        pulse_start(0, 1'b0);
        run(5, "zero_len");
        check_count("busy_after_zero_len", int'(busy), 0);

        n_done_seen = 0;
        pulse_start(1, 1'b0);
        run(999, "stop_terminal");
        stop = 1'b1;
        step_cycle("stop_terminal");
        stop = 1'b0;
        run(5, "stop_terminal");
        check_count("stop_terminal_done_pulses", n_done_seen, 0);

        pulse_start(3, 1'b0);
        run(1500, "pre_reset");
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_output("reset_in_play");
        #2;
        reset_n = 1'b1;
        run(5, "post_reset");

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) begin
                for (int a = 0; a < DEPTH; a++) write_entry(c, a, rand_h());
            end
            pulse_start($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 3500; i++) begin
                if ($urandom_range(0, 39) == 0) begin
                    wr_en = 1'b1; wr_ch = 1'($urandom_range(0, 1));
                    wr_addr = 2'($urandom_range(0, 3)); wr_data = 8'(rand_h());
                end
                stop  = ($urandom_range(0, 2499) == 0);
                start = ($urandom_range(0, 299) == 0);
                step_cycle("random");
                wr_en = 1'b0; stop = 1'b0; start = 1'b0;
            end
            stop = 1'b1;
            step_cycle("random_stop");
            stop = 1'b0;
            run(3, "random_idle");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
